data_sram_responder: RTL and testbench

- Memory-side responder for the CPU's synchronous SRAM data interface: accepts write-enable/address/write-data each cycle and returns read data after a fixed latency.
- Backs a word-addressed storage array mapped at a base address.
- Flags out-of-range accesses and counts traffic for debug.
- Sits between the CPU top's data_sram_* ports and the SoC; inst-side instances use sram_we tied low.

---
 rtl/data_sram_responder_pkg.sv | 23 ++
 rtl/data_sram_responder_if.sv | 23 ++
 rtl/data_sram_responder_lat_pipe.sv | 46 ++++
 rtl/data_sram_responder.sv | 87 ++++++++
 tb/tb_data_sram_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared widths, defaults and address decode for the data-side SRAM responder.
// Combinational only; no latency, no backpressure.
package mem_pkg;

  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int DEF_DEPTH_LOG2 = 14;
  localparam int MAX_RD_LAT     = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t DEF_BASE_ADDR = 32'h1c00_0000;

  // 33-bit compare keeps the window size exact even when it spans 4 GiB.
  function automatic logic addr_in_range(input addr_t addr, input addr_t base,
                                         input int depth_log2);
    addr_t off;
    off = addr - base;
    return (addr >= base) && ({1'b0, off} < (33'd4 << depth_log2));
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU-side synchronous SRAM data port: request fields from the CPU, read result back.
// No backpressure: one request per cycle, results return after a fixed latency.
interface data_sram_responder_if;
  import mem_pkg::*;

  logic  sram_en;
  logic  sram_we;
  addr_t sram_addr;
  data_t sram_wdata;
  data_t sram_rdata;
  logic  sram_rvalid;

  modport master (
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata, sram_rvalid
  );

  modport slave (
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata, sram_rvalid
  );

endinterface

// File: rtl/data_sram_responder_lat_pipe.sv
// Valid+data delay line of RD_LAT register stages; data only moves with a valid,
// so the output holds its last result between valids. No backpressure.
module lat_pipe
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  in_vld,
  input  data_t in_dat,
  output logic  out_vld,
  output data_t out_dat
);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("lat_pipe: RD_LAT must be within 1..%0d", MAX_RD_LAT);
  end

  logic [RD_LAT-1:0] vld_q;
  data_t             dat_q [RD_LAT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) begin
        dat_q[0] <= in_dat;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/data_sram_responder.sv
// Word-addressed storage behind the CPU data SRAM port; reads return after RD_LAT edges,
// out-of-range accesses are flagged and counted. Never stalls: one access per cycle.
module data_sram_responder
  import mem_pkg::*;
#(
  parameter addr_t BASE_ADDR  = DEF_BASE_ADDR,
  parameter int    DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int    RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  data_sram_responder_if.slave  sram,
  output logic                  err,
  output addr_t                 err_addr,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  addr_t                 off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_hit;
  data_t                 rd_dat;

  data_t mem [WORDS];

  assign off      = sram.sram_addr - BASE_ADDR;
  assign in_range = addr_in_range(sram.sram_addr, BASE_ADDR, DEPTH_LOG2);
  assign idx      = off[DEPTH_LOG2+1:2];

  assign rd_acc = sram.sram_en & ~sram.sram_we;
  assign wr_acc = sram.sram_en &  sram.sram_we;
  assign wr_hit = wr_acc & in_range;

  // Read-first: the array value sampled here is the one before any write on this edge.
  assign rd_dat = in_range ? mem[idx] : '0;

  // Storage is deliberately not reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[idx] <= sram.sram_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_acc) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (wr_acc) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

  // Only the first out-of-range address is kept; later ones leave err_addr alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (sram.sram_en && !in_range) begin
      err <= 1'b1;
      if (!err) begin
        err_addr <= sram.sram_addr;
      end
    end
  end

  lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .in_vld  (rd_acc),
    .in_dat  (rd_dat),
    .out_vld (sram.sram_rvalid),
    .out_dat (sram.sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Drives identical traffic into an RD_LAT=1 and an RD_LAT=3 responder and checks both
// against a per-request result history and an associative-array memory model.
module tb_data_sram_responder;
  import mem_pkg::*;

  localparam logic [31:0] BASE   = 32'h1c00_0000;
  localparam int          DL2    = 14;
  localparam longint      BASE_L = longint'({32'd0, BASE});
  localparam longint      SPAN   = longint'(4) << DL2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  data_sram_responder_if bus1 ();
  data_sram_responder_if bus3 ();

  logic        err1, err3;
  logic [31:0] ea1, ea3, rc1, rc3, wc1, wc3;

  data_sram_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .RD_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .sram(bus1),
    .err(err1), .err_addr(ea1), .rd_cnt(rc1), .wr_cnt(wc1)
  );

  data_sram_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .RD_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .sram(bus3),
    .err(err3), .err_addr(ea3), .rd_cnt(rc3), .wr_cnt(wc3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, one history entry per clock edge, expected outputs.
  logic [31:0] mm [int];
  bit          hv [$];
  logic [31:0] hd [$];
  bit          e_v1, e_v3;
  logic [31:0] e_d1, e_d3;
  logic [31:0] m_rd, m_wr, m_ea;
  bit          m_err;

  task automatic model_clear();
    hv.delete();
    hd.delete();
    e_v1 = 0; e_v3 = 0; e_d1 = '0; e_d3 = '0;
    m_rd = '0; m_wr = '0; m_err = 0; m_ea = '0;
  endtask

  task automatic drive(input bit en, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus1.sram_en = en; bus1.sram_we = we; bus1.sram_addr = a; bus1.sram_wdata = d;
    bus3.sram_en = en; bus3.sram_we = we; bus3.sram_addr = a; bus3.sram_wdata = d;
  endtask

  // One clock edge with the given request; returns #1 after the edge.
  task automatic step(input bit en, input bit we, input logic [31:0] a, input logic [31:0] d);
    longint      la;
    bit          inr;
    int          w;
    bit          rv;
    logic [31:0] rd;
    int          n;
    drive(en, we, a, d);
    @(posedge clk);
    la  = longint'({32'd0, a});
    inr = (la >= BASE_L) && (la < BASE_L + SPAN);
    w   = int'((la - BASE_L) / 4);
    rv  = 0;
    rd  = '0;
    if (en) begin
      if (!inr && !m_err) begin
        m_err = 1;
        m_ea  = a;
      end
      if (we) begin
        m_wr = m_wr + 32'd1;
        if (inr) mm[w] = d;
      end else begin
        m_rd = m_rd + 32'd1;
        rv   = 1;
        if (inr && mm.exists(w)) rd = mm[w];
      end
    end
    hv.push_back(rv);
    hd.push_back(rd);
    n = hv.size();
    if (hv[n-1]) begin e_v1 = 1; e_d1 = hd[n-1]; end else e_v1 = 0;
    if (n >= 3 && hv[n-3]) begin e_v3 = 1; e_d3 = hd[n-3]; end else e_v3 = 0;
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, '0, '0);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    drive(0, 0, '0, '0);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus1.sram_rvalid !== 1'b0 || bus3.sram_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rvalid: got %b/%b want 0/0", bus1.sram_rvalid, bus3.sram_rvalid);
    end
    resetn = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, '0);
      checks++;
      if (bus1.sram_rvalid !== 1'b0 || bus3.sram_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL idle_rvalid cycle %0d: got %b/%b want 0/0", i, bus1.sram_rvalid, bus3.sram_rvalid);
      end
    end
    checks++;
    if (bus1.sram_rdata !== 32'd0 || bus3.sram_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0", bus1.sram_rdata, bus3.sram_rdata);
    end
    checks++;
    if ({err1, err3} !== 2'b00 || ea1 !== 32'd0 || ea3 !== 32'd0) begin
      errors++;
      $display("FAIL reset_err: got err %b/%b addr %h/%h want 0", err1, err3, ea1, ea3);
    end
    checks++;
    if (rc1 !== 32'd0 || wc1 !== 32'd0 || rc3 !== 32'd0 || wc3 !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got rd %0d/%0d wr %0d/%0d want 0", rc1, rc3, wc1, wc3);
    end
  endtask

  task automatic test_write_read();
    step(1, 1, BASE + 32'h10, 32'hDEAD_BEEF);
    step(1, 0, BASE + 32'h10, '0);
    checks++;
    if (bus1.sram_rvalid !== 1'b1 || bus1.sram_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_rd_lat1: got v=%b d=%h want v=1 d=deadbeef", bus1.sram_rvalid, bus1.sram_rdata);
    end
    checks++;
    if (rc1 !== 32'd1 || wc1 !== 32'd1) begin
      errors++;
      $display("FAIL wr_rd_cnt: got rd=%0d wr=%0d want 1/1", rc1, wc1);
    end
    step(0, 0, '0, '0);
    step(0, 0, '0, '0);
    checks++;
    if (bus3.sram_rvalid !== 1'b1 || bus3.sram_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_rd_lat3: got v=%b d=%h want v=1 d=deadbeef", bus3.sram_rvalid, bus3.sram_rdata);
    end
  endtask

  task automatic test_alias();
    step(1, 1, BASE + 32'h10, 32'h1111_1111);
    step(1, 1, BASE + 32'h10, 32'h2222_2222);
    step(1, 0, BASE + 32'h13, '0);
    checks++;
    if (bus1.sram_rdata !== 32'h2222_2222) begin
      errors++;
      $display("FAIL alias_rd: got %h want 22222222", bus1.sram_rdata);
    end
    // Read the old word, overwrite it, then read again: old then new.
    step(1, 0, BASE + 32'h11, '0);
    step(1, 1, BASE + 32'h12, 32'h3333_3333);
    step(1, 0, BASE + 32'h10, '0);
    checks++;
    if (bus1.sram_rdata !== 32'h3333_3333) begin
      errors++;
      $display("FAIL rewrite_rd: got %h want 33333333", bus1.sram_rdata);
    end
    step(0, 0, '0, '0);
    checks++;
    if (bus3.sram_rvalid !== 1'b0 || bus3.sram_rdata !== 32'h2222_2222) begin
      errors++;
      $display("FAIL alias_lat3_hold: got v=%b d=%h want v=0 d=22222222", bus3.sram_rvalid, bus3.sram_rdata);
    end
    step(0, 0, '0, '0);
    checks++;
    if (bus3.sram_rvalid !== 1'b1 || bus3.sram_rdata !== 32'h3333_3333) begin
      errors++;
      $display("FAIL alias_lat3: got v=%b d=%h want v=1 d=33333333", bus3.sram_rvalid, bus3.sram_rdata);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] wc_before;
    step(1, 1, BASE, 32'hA5A5_0000);
    step(1, 0, 32'h1bff_fffc, '0);
    checks++;
    if (bus1.sram_rvalid !== 1'b1 || bus1.sram_rdata !== 32'd0) begin
      errors++;
      $display("FAIL oor_rd: got v=%b d=%h want v=1 d=0", bus1.sram_rvalid, bus1.sram_rdata);
    end
    checks++;
    if (err1 !== 1'b1 || ea1 !== 32'h1bff_fffc) begin
      errors++;
      $display("FAIL oor_err: got err=%b addr=%h want 1 1bfffffc", err1, ea1);
    end
    wc_before = wc1;
    step(1, 1, 32'h1c01_0000, 32'hFFFF_FFFF);
    checks++;
    if (err1 !== 1'b1 || ea1 !== 32'h1bff_fffc || wc1 !== wc_before + 32'd1) begin
      errors++;
      $display("FAIL oor_wr: got err=%b addr=%h wr=%0d want 1 1bfffffc %0d", err1, ea1, wc1, wc_before + 1);
    end
    step(1, 0, BASE, '0);
    checks++;
    if (bus1.sram_rdata !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL oor_mem_kept: got %h want a5a50000", bus1.sram_rdata);
    end
    step(1, 1, BASE + 32'h0000_fffc, 32'h7777_0001);
    step(1, 0, BASE + 32'h0000_fffc, '0);
    checks++;
    if (bus1.sram_rdata !== 32'h7777_0001 || ea1 !== 32'h1bff_fffc) begin
      errors++;
      $display("FAIL last_word: got %h ea=%h want 77770001 1bfffffc", bus1.sram_rdata, ea1);
    end
    step(0, 0, '0, '0);
    step(0, 0, '0, '0);
    checks++;
    if (bus3.sram_rdata !== 32'h7777_0001 || err3 !== 1'b1 || ea3 !== 32'h1bff_fffc) begin
      errors++;
      $display("FAIL oor_lat3: got d=%h err=%b ea=%h want 77770001 1 1bfffffc", bus3.sram_rdata, err3, ea3);
    end
  endtask

  task automatic test_fill();
    for (int w = 0; w < 64; w++) begin
      step(1, 1, BASE + 32'(w * 4), $urandom);
    end
    checks++;
    if (wc1 !== m_wr || wc3 !== m_wr) begin
      errors++;
      $display("FAIL fill_wr_cnt: got %0d/%0d want %0d", wc1, wc3, m_wr);
    end
  endtask

  task automatic test_latency();
    logic [7:0] p1, p3;
    bit         en_t [8] = '{1, 1, 1, 0, 1, 0, 0, 0};
    int         wd_t [8] = '{0, 1, 2, 0, 3, 0, 0, 0};
    p1 = '0;
    p3 = '0;
    for (int k = 0; k < 8; k++) begin
      step(en_t[k], 0, BASE + 32'(wd_t[k] * 4), '0);
      p1[k] = bus1.sram_rvalid;
      p3[k] = bus3.sram_rvalid;
      checks++;
      if (bus3.sram_rdata !== e_d3) begin
        errors++;
        $display("FAIL lat3_data cycle %0d: got %h want %h", k, bus3.sram_rdata, e_d3);
      end
    end
    checks++;
    if (p1 !== 8'b0001_0111) begin
      errors++;
      $display("FAIL lat1_pattern: got %b want 00010111", p1);
    end
    checks++;
    if (p3 !== 8'b0101_1100) begin
      errors++;
      $display("FAIL lat3_pattern: got %b want 01011100", p3);
    end
  endtask

  task automatic test_random();
    logic [31:0] oor [4] = '{32'h1bff_fffc, 32'h1c01_0000, 32'h0000_0000, 32'hffff_fffc};
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      else a = oor[$urandom_range(0, 3)];
      step(r != 9, $urandom_range(0, 2) == 0, a, $urandom);
      checks++;
      if (bus1.sram_rvalid !== e_v1 || bus1.sram_rdata !== e_d1) begin
        errors++;
        $display("FAIL rand_lat1 #%0d: got v=%b d=%h want v=%b d=%h", i, bus1.sram_rvalid, bus1.sram_rdata, e_v1, e_d1);
      end
      checks++;
      if (bus3.sram_rvalid !== e_v3 || bus3.sram_rdata !== e_d3) begin
        errors++;
        $display("FAIL rand_lat3 #%0d: got v=%b d=%h want v=%b d=%h", i, bus3.sram_rvalid, bus3.sram_rdata, e_v3, e_d3);
      end
    end
    checks++;
    if (rc1 !== m_rd || rc3 !== m_rd || wc1 !== m_wr || wc3 !== m_wr) begin
      errors++;
      $display("FAIL rand_cnt: got rd %0d/%0d wr %0d/%0d want %0d %0d", rc1, rc3, wc1, wc3, m_rd, m_wr);
    end
    checks++;
    if (err1 !== m_err || ea1 !== m_ea || err3 !== m_err || ea3 !== m_ea) begin
      errors++;
      $display("FAIL rand_err: got %b %h / %b %h want %b %h", err1, ea1, err3, ea3, m_err, m_ea);
    end
  endtask

  task automatic test_reset_midflight();
    step(1, 0, BASE, '0);
    step(1, 0, BASE + 32'h4, '0);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0, '0);
      checks++;
      if (bus1.sram_rvalid !== 1'b0 || bus3.sram_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_rvalid cycle %0d: got %b/%b want 0/0", i, bus1.sram_rvalid, bus3.sram_rvalid);
      end
    end
    checks++;
    if (rc1 !== 32'd0 || wc1 !== 32'd0 || rc3 !== 32'd0 || wc3 !== 32'd0 || err1 !== 1'b0 || err3 !== 1'b0) begin
      errors++;
      $display("FAIL midflight_state: got rd %0d/%0d wr %0d/%0d err %b/%b want 0", rc1, rc3, wc1, wc3, err1, err3);
    end
    step(1, 0, BASE + 32'h14, '0);
    checks++;
    if (bus1.sram_rvalid !== 1'b1 || bus1.sram_rdata !== mm[5]) begin
      errors++;
      $display("FAIL persist_lat1: got v=%b d=%h want v=1 d=%h", bus1.sram_rvalid, bus1.sram_rdata, mm[5]);
    end
    step(0, 0, '0, '0);
    step(0, 0, '0, '0);
    checks++;
    if (bus3.sram_rvalid !== 1'b1 || bus3.sram_rdata !== mm[5] || rc3 !== 32'd1) begin
      errors++;
      $display("FAIL persist_lat3: got v=%b d=%h rd=%0d want v=1 d=%h rd=1", bus3.sram_rvalid, bus3.sram_rdata, rc3, mm[5]);
    end
  endtask

  initial begin
    model_clear();
    drive(0, 0, '0, '0);
    test_reset();
    test_write_read();
    test_alias();
    test_out_of_range();
    test_fill();
    test_latency();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
